// File: rtl/count_seg_display.sv
// count_seg_display
// Converts two 7-bit binary counts to BCD with a shared-schedule double-dabble
// converter and time-multiplexes the four resulting digits onto one
// 7-segment output.
//
// Build option: define LEADING_ZERO_BLANK_EN to store a zero tens digit
// (non-dash) as the blank code instead of "0".
//
// Digit registers hold a 4-bit code (0..9 digit, DASH, BLANK); segment
// patterns are decoded only on scan edges.
module count_seg_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] cnt_a,
    input  logic [6:0] cnt_b,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       upd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hB;
    localparam int         DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [11:0] dd_adj(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] >= 4'd5) begin
            r[3:0] = v[3:0] + 4'd3;
        end
        if (v[7:4] >= 4'd5) begin
            r[7:4] = v[7:4] + 4'd3;
        end
        if (v[11:8] >= 4'd5) begin
            r[11:8] = v[11:8] + 4'd3;
        end
        return r;
    endfunction

    // Digit code to active-high segment pattern (seg[0]=a ... seg[6]=g).
    function automatic logic [6:0] seg_dec(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:       s = 7'h3F;
            4'd1:       s = 7'h06;
            4'd2:       s = 7'h5B;
            4'd3:       s = 7'h4F;
            4'd4:       s = 7'h66;
            4'd5:       s = 7'h6D;
            4'd6:       s = 7'h7D;
            4'd7:       s = 7'h07;
            4'd8:       s = 7'h7F;
            4'd9:       s = 7'h6F;
            CODE_DASH:  s = 7'h40;
            CODE_BLANK: s = 7'h00;
            default:    s = 7'h00;
        endcase
        return s;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [2:0]       bit_cnt_r;
    logic [6:0]       cap_a_r;
    logic [6:0]       cap_b_r;
    logic [11:0]      acc_a_r;
    logic [11:0]      acc_b_r;
    logic [11:0]      adj_a_s;
    logic [11:0]      adj_b_s;
    logic [3:0]       dig_r [4];
    logic [3:0]       ones_a_s;
    logic [3:0]       tens_a_s;
    logic [3:0]       ones_b_s;
    logic [3:0]       tens_b_s;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       idx_r;
    logic [1:0]       idx_next_s;
    logic             blank_en_s;

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_en_s = 1'b1;
`else
    assign blank_en_s = 1'b0;
`endif

    // Converter next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = SHIFT;
            SHIFT: begin
                if (bit_cnt_r == 3'd6) begin
                    state_s = LOAD;
                end else begin
                    state_s = SHIFT;
                end
            end
            LOAD:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Per-channel add-3 correction and final digit codes; a non-zero
    // hundreds nibble means the channel is above 99 and shows dashes.
    always_comb begin
        adj_a_s  = dd_adj(acc_a_r);
        adj_b_s  = dd_adj(acc_b_r);
        ones_a_s = acc_a_r[3:0];
        tens_a_s = acc_a_r[7:4];
        ones_b_s = acc_b_r[3:0];
        tens_b_s = acc_b_r[7:4];
        if (acc_a_r[11:8] != 4'd0) begin
            ones_a_s = CODE_DASH;
            tens_a_s = CODE_DASH;
        end else if (blank_en_s && (acc_a_r[7:4] == 4'd0)) begin
            tens_a_s = CODE_BLANK;
        end else begin
            tens_a_s = acc_a_r[7:4];
        end
        if (acc_b_r[11:8] != 4'd0) begin
            ones_b_s = CODE_DASH;
            tens_b_s = CODE_DASH;
        end else if (blank_en_s && (acc_b_r[7:4] == 4'd0)) begin
            tens_b_s = CODE_BLANK;
        end else begin
            tens_b_s = acc_b_r[7:4];
        end
    end

    // Converter state register and datapath: capture, shift, load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= 3'd0;
            cap_a_r   <= 7'd0;
            cap_b_r   <= 7'd0;
            acc_a_r   <= 12'd0;
            acc_b_r   <= 12'd0;
            dig_r[0]  <= 4'd0;
            dig_r[1]  <= 4'd0;
            dig_r[2]  <= 4'd0;
            dig_r[3]  <= 4'd0;
            upd       <= 1'b0;
        end else begin
            state_r <= state_s;
            upd     <= (state_r == LOAD);
            case (state_r)
                IDLE: begin
                    cap_a_r   <= cnt_a;
                    cap_b_r   <= cnt_b;
                    acc_a_r   <= 12'd0;
                    acc_b_r   <= 12'd0;
                    bit_cnt_r <= 3'd0;
                end
                SHIFT: begin
                    acc_a_r   <= {adj_a_s[10:0], cap_a_r[6]};
                    acc_b_r   <= {adj_b_s[10:0], cap_b_r[6]};
                    cap_a_r   <= {cap_a_r[5:0], 1'b0};
                    cap_b_r   <= {cap_b_r[5:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
                LOAD: begin
                    dig_r[0] <= ones_a_s;
                    dig_r[1] <= tens_a_s;
                    dig_r[2] <= ones_b_s;
                    dig_r[3] <= tens_b_s;
                end
                default: begin
                    bit_cnt_r <= 3'd0;
                end
            endcase
        end
    end

    assign idx_next_s = idx_r + 2'd1;

    // Scan divider and digit multiplexer; an and seg move together on the
    // divider terminal count and read digit registers as they were before
    // this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= '0;
            idx_r <= 2'd0;
            an    <= 4'b0001;
            seg   <= 7'h3F;
        end else if (div_r == DIV_LAST) begin
            div_r <= '0;
            idx_r <= idx_next_s;
            an    <= 4'b0001 << idx_next_s;
            seg   <= seg_dec(dig_r[idx_next_s]);
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

endmodule

// File: tb/tb_count_seg_display.sv
// Testbench for count_seg_display: a cycle-level reference model for two
// instances (SCAN_DIV=2 and SCAN_DIV=1) compared on every falling edge,
// plus directed literal checks. Honours LEADING_ZERO_BLANK_EN.
module tb_count_seg_display;

    logic       clk;
    logic       rst_n;
    logic [6:0] cnt_a;
    logic [6:0] cnt_b;
    logic [6:0] seg0, seg1;
    logic [3:0] an0, an1;
    logic       upd0, upd1;

    int checks;
    int failures;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    count_seg_display #(.SCAN_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_a(cnt_a), .cnt_b(cnt_b),
        .seg(seg0), .an(an0), .upd(upd0)
    );

    count_seg_display #(.SCAN_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cnt_a(cnt_a), .cnt_b(cnt_b),
        .seg(seg1), .an(an1), .upd(upd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int         lim [2] = '{2, 1};
    int         n;
    int         mdiv [2];
    int         midx [2];
    int         cap_a, cap_b;
    logic [6:0] mdig [4];
    logic [6:0] exp_seg [2];
    logic [3:0] exp_an [2];
    logic       exp_upd;

    task automatic model_load(input int base, input int v);
        if (v > 99) begin
            mdig[base]   = 7'h40;
            mdig[base+1] = 7'h40;
        end else begin
            mdig[base] = seg_tab[v % 10];
            if (BLANK && (v / 10 == 0)) mdig[base+1] = 7'h00;
            else                        mdig[base+1] = seg_tab[v / 10];
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; cap_a = 0; cap_b = 0; exp_upd = 1'b0;
            for (int d = 0; d < 4; d++) mdig[d] = 7'h3F;
            for (int k = 0; k < 2; k++) begin
                mdiv[k] = 0; midx[k] = 0; exp_an[k] = 4'b0001; exp_seg[k] = 7'h3F;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (mdiv[k] == lim[k] - 1) begin
                    mdiv[k]    = 0;
                    midx[k]    = (midx[k] + 1) % 4;
                    exp_an[k]  = 4'(1 << midx[k]);
                    exp_seg[k] = mdig[midx[k]];
                end else begin
                    mdiv[k]++;
                end
            end
            exp_upd = (n % 9 == 8);
            if (n % 9 == 0) begin
                cap_a = int'(cnt_a);
                cap_b = int'(cnt_b);
            end
            if (n % 9 == 8) begin
                model_load(0, cap_a);
                model_load(2, cap_b);
            end
            n++;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        checks++;
        if (seg0 !== exp_seg[0] || an0 !== exp_an[0] || upd0 !== exp_upd) begin
            failures++;
            $display("FAIL cyc_div2 t=%0t got seg=%h an=%b upd=%b want seg=%h an=%b upd=%b",
                     $time, seg0, an0, upd0, exp_seg[0], exp_an[0], exp_upd);
        end
        checks++;
        if (seg1 !== exp_seg[1] || an1 !== exp_an[1] || upd1 !== exp_upd) begin
            failures++;
            $display("FAIL cyc_div1 t=%0t got seg=%h an=%b upd=%b want seg=%h an=%b upd=%b",
                     $time, seg1, an1, upd1, exp_seg[1], exp_an[1], exp_upd);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Counts falling edges until upd is seen high (bounded).
    task automatic wait_upd(output int cyc);
        cyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cyc++;
            if (upd0) return;
        end
        cyc = -1;
    endtask

    // Waits for an to step into an_val, then checks seg against a literal.
    task automatic check_digit(input string name, input logic [3:0] an_val,
                               input logic [6:0] want);
        logic [3:0] prev;
        prev = an0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an0 == an_val && prev != an_val) begin
                check(name, int'(seg0), int'(want));
                return;
            end
            prev = an0;
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    task automatic settle(input logic [6:0] a, input logic [6:0] b);
        int c;
        @(negedge clk);
        cnt_a = a;
        cnt_b = b;
        wait_upd(c);
        wait_upd(c);
        check("settle_upd_period", c, 9);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        cnt_a = 7'd0;
        cnt_b = 7'd50;
        repeat (3) @(negedge clk);
        check("rst_an", int'(an0), 4'b0001);
        check("rst_seg", int'(seg0), 7'h3F);
        check("rst_upd", int'(upd0), 0);

        // Timing: first upd 9 edges after release, then every 9.
        @(negedge clk);
        rst_n = 1'b1;
        wait_upd(c);
        check("first_upd_cycles", c, 9);
        check("model_dig2_50", int'(mdig[2]), 7'h3F);
        check("model_dig3_50", int'(mdig[3]), 7'h6D);
        wait_upd(c);
        check("second_upd_cycles", c, 9);
        check_digit("t_an0", 4'b0001, 7'h3F);
        check_digit("t_an1", 4'b0010, BLANK ? 7'h00 : 7'h3F);
        check_digit("t_an2", 4'b0100, 7'h3F);
        check_digit("t_an3", 4'b1000, 7'h6D);

        // Decode 49 / 99.
        settle(7'd49, 7'd99);
        check_digit("d_an0", 4'b0001, 7'h6F);
        check_digit("d_an1", 4'b0010, 7'h66);
        check_digit("d_an2", 4'b0100, 7'h6F);
        check_digit("d_an3", 4'b1000, 7'h6F);

        // Leading zero.
        settle(7'd7, 7'd60);
        check_digit("b_an0", 4'b0001, 7'h07);
        check_digit("b_an1", 4'b0010, BLANK ? 7'h00 : 7'h3F);
        check_digit("b_an3", 4'b1000, 7'h7D);

        // Over-range, including the 100 boundary.
        settle(7'd127, 7'd100);
        check_digit("o_an0", 4'b0001, 7'h40);
        check_digit("o_an1", 4'b0010, 7'h40);
        check_digit("o_an2", 4'b0100, 7'h40);
        check_digit("o_an3", 4'b1000, 7'h40);
        settle(7'd99, 7'd98);
        check_digit("r99_an1", 4'b0010, 7'h6F);
        check_digit("r98_an2", 4'b0100, 7'h7F);

        // Input change the cycle after capture.
        wait_upd(c);
        cnt_a = 7'd12;
        @(negedge clk);
        cnt_a = 7'd34;
        wait_upd(c);
        check("mid_upd_cycles", c, 8);
        check("model_mid_ones12", int'(mdig[0]), 7'h5B);
        check("model_mid_tens12", int'(mdig[1]), 7'h06);
        check_digit("mid_12_an0", 4'b0001, 7'h5B);
        wait_upd(c);
        check("model_mid_ones34", int'(mdig[0]), 7'h66);
        wait_upd(c);
        check_digit("mid_34_an0", 4'b0001, 7'h66);
        check_digit("mid_34_an1", 4'b0010, 7'h4F);

        // Reset during SHIFT: immediate reset outputs, no upd, restart.
        wait_upd(c);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_an", int'(an0), 4'b0001);
        check("mrst_seg", int'(seg0), 7'h3F);
        check("mrst_upd", int'(upd0), 0);
        check("mrst_an1", int'(an1), 4'b0001);
        repeat (2) @(negedge clk);
        check("mrst_hold_upd", int'(upd0), 0);
        rst_n = 1'b1;
        wait_upd(c);
        check("mrst_first_upd", c, 9);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_seg_display.md
COUNT_SEG_DISPLAY -- requirements
Module: count_seg_display

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per displayed digit; legal range is 1 or more.
REQ-002 clk  input  1  clock; all state is updated on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cnt_a  input  7  first binary count to display; nominal range is 0..49.
REQ-005 cnt_b  input  7  second binary count to display; nominal range is 50..99.
REQ-006 seg  output  7  registered active-high segments; seg[0]=a ... seg[6]=g.
REQ-007 an  output  4  registered one-hot active-high digit enables.
- an[0]: cnt_a ones.
- an[1]: cnt_a tens.
- an[2]: cnt_b ones.
- an[3]: cnt_b tens.
REQ-008 upd  output  1  registered one-cycle pulse marking that new digit registers were written.

Function
REQ-009 The converter FSM SHALL use states IDLE, SHIFT and LOAD.
- IDLE->SHIFT unconditionally.
- SHIFT->SHIFT while the bit counter is below 6.
- SHIFT->LOAD on bit count 6.
- LOAD->IDLE unconditionally.
REQ-010 On the edge leaving IDLE, the block SHALL capture cnt_a and cnt_b, clear the BCD accumulators and clear the 3-bit bit counter.
REQ-011 Each SHIFT edge SHALL perform one double-dabble step per channel, MSB first.
- Add 3 to any BCD nibble that is 5 or more.
- Then shift the next captured bit in.
REQ-012 On the LOAD edge, the block SHALL write the four digit registers, and upd SHALL be 1 for exactly the following cycle.
REQ-013 Conversion period SHALL be exactly 9 cycles: capture edge E0, shift edges E1..E7, load edge E8, next capture edge E9.
REQ-014 Input changes after E0 SHALL NOT affect the conversion in progress.
REQ-015 A channel value above 99 SHALL set both of that channel's digit registers to the dash code, displayed as seg=7'h40.
REQ-016 Digit decode SHALL be:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Dash code = 40.
- Blank code = 00.
REQ-017 The scan divider SHALL count 0..SCAN_DIV-1.
- On its terminal count, the digit index (0..3) SHALL advance and wrap from 3 to 0.
- an SHALL follow the index one-hot.
- seg SHALL be the decode of the selected digit register; both are registered together on the same edge.
REQ-018 With SCAN_DIV=1, the index SHALL advance every cycle.
REQ-019 Scanning SHALL run independently of the converter FSM; a digit register write SHALL take effect on seg at the next scan edge that selects that digit.

Reset
REQ-020 While rst_n=0, all of the following SHALL hold immediately, regardless of clk:
- FSM=IDLE.
- Bit counter, accumulators, captures, divider and digit index = 0.
- All digit registers = digit 0.
- upd=0, an=4'b0001, seg=7'h3F.
REQ-021 Reset asserted mid-SHIFT SHALL abandon the conversion with no upd pulse.
REQ-022 After rst_n deassertion, the first capture SHALL occur on the first rising clk edge.

Configuration
REQ-023 Macro LEADING_ZERO_BLANK_EN, when defined: a tens digit of 0 (non-dash) SHALL be stored as the blank code, giving seg=7'h00 while selected.
REQ-024 Macro LEADING_ZERO_BLANK_EN, when not defined: a tens digit of 0 SHALL display as seg=7'h3F.

Verification
REQ-025 Timing: SCAN_DIV=2, cnt_a=0, cnt_b=50, release reset.
- upd SHALL pulse 9 cycles after the first capture, then every 9 cycles.
- an SHALL step 0001, 0010, 0100, 1000 every 2 cycles.
- seg SHALL then be 3F, 3F, 3F, 6D.
REQ-026 Decode: cnt_a=49, cnt_b=99 -> seg per an SHALL be 6F, 66, 6F, 6F.
REQ-027 Blanking: cnt_a=7 -> an=0010 with seg=00 when LEADING_ZERO_BLANK_EN is defined, and seg=3F when it is not; an=0001 with seg=07 in both builds.
REQ-028 Over-range: cnt_a=127, cnt_b=100 -> all four digits SHALL show seg=40.
REQ-029 Mid-operation events:
- Change cnt_a from 12 to 34 on the cycle after capture -> the next upd SHALL show 12; the following upd SHALL show 34.
- Assert rst_n low during SHIFT -> same-cycle an=0001, seg=3F, upd=0.
